// File: rtl/regfile_n_if.sv
// regfile_n_if: write/read/clear signal bundle for regfile_n.
//   W_data/W_addr/W_en      : write port
//   R_addrX/R_enX/R_dataX   : two independent registered read ports (X = 0, 1)
//   Clr/Busy/Done           : clear request, clear-in-progress flag, completion pulse
interface regfile_n_if #(
    parameter int N = 16,
    parameter int A = 4
);
    logic [N-1:0] W_data;
    logic [A-1:0] W_addr;
    logic         W_en;
    logic [A-1:0] R_addr0;
    logic [A-1:0] R_addr1;
    logic         R_en0;
    logic         R_en1;
    logic [N-1:0] R_data0;
    logic [N-1:0] R_data1;
    logic         Clr;
    logic         Busy;
    logic         Done;

    modport master (
        output W_data, W_addr, W_en, R_addr0, R_addr1, R_en0, R_en1, Clr,
        input  R_data0, R_data1, Busy, Done
    );

    modport slave (
        input  W_data, W_addr, W_en, R_addr0, R_addr1, R_en0, R_en1, Clr,
        output R_data0, R_data1, Busy, Done
    );
endinterface

// File: rtl/regfile_n.sv
// regfile_n: 2^A x N register file, one write port, two registered read ports, sequential clear.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : regfile_n_if slave (write port, read ports 0/1, Clr/Busy/Done)
module regfile_n #(
    parameter int N = 16,
    parameter int A = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    regfile_n_if.slave  bus
);
    localparam int D = 1 << A;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t       state_q, state_d;
    logic [A-1:0] cc_q, cc_d;
    logic         done_q, done_d;
    logic [N-1:0] mem_q [D];
    logic [N-1:0] mem_d [D];
    logic [N-1:0] r_data0_q, r_data0_d;
    logic [N-1:0] r_data1_q, r_data1_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            done_q  <= done_d;
        end
    end

    // The last clear step is the one whose counter is all ones (D-1).
    always_comb begin
        state_d = state_q == IDLE ? (bus.Clr ? CLEAR : IDLE) : (&cc_q ? IDLE : CLEAR);
        cc_d    = state_q == IDLE ? '0 : cc_q + 1'b1;
        done_d  = state_q == CLEAR && &cc_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_q     <= '{default: '0};
            r_data0_q <= '0;
            r_data1_q <= '0;
        end else begin
            mem_q     <= mem_d;
            r_data0_q <= r_data0_d;
            r_data1_q <= r_data1_d;
        end
    end

    // Reads index the post-update array, which gives write-through and clear bypass.
    always_comb begin
        mem_d = mem_q;
        if (state_q == IDLE && bus.W_en) mem_d[bus.W_addr] = bus.W_data;
        if (state_q == CLEAR) mem_d[cc_q] = '0;
        r_data0_d = bus.R_en0 ? mem_d[bus.R_addr0] : '0;
        r_data1_d = bus.R_en1 ? mem_d[bus.R_addr1] : '0;
    end

    assign bus.Busy    = state_q == CLEAR;
    assign bus.Done    = done_q;
    assign bus.R_data0 = r_data0_q;
    assign bus.R_data1 = r_data1_q;
endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n: scoreboard bench for regfile_n at 16x16 and 8x8.
module tb_regfile_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_n_if #(.N(16), .A(4)) ia ();
    regfile_n_if #(.N(8),  .A(3)) ib ();

    regfile_n #(.N(16), .A(4)) dut_a (.Clk(clk), .Reset(rst_n), .bus(ia));
    regfile_n #(.N(8),  .A(3)) dut_b (.Clk(clk), .Reset(rst_n), .bus(ib));

    typedef struct {
        int b;
        bit c;
        bit bz;
        bit dn;
    } st_t;

    st_t         sq[$];
    logic [15:0] qa0[$], qa1[$], qb0[$], qb1[$];
    int          errors = 0;
    int          checks = 0;
    bit          fin = 1'b0;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] m(input int b, input logic [15:0] v);
        return b != 0 ? {8'h00, v[7:0]} : v;
    endfunction

    function automatic logic [15:0] pat(input int b, input int i);
        return m(b, 16'hA0B0 + 16'(i));
    endfunction

    task automatic cyc(input int b, input bit we, input int wa, input logic [15:0] wd,
                       input bit r0, input int a0, input logic [15:0] e0,
                       input bit r1, input int a1, input logic [15:0] e1,
                       input bit clr, input bit sc, input bit eb, input bit ed);
        st_t s;
        ia.W_en = 0; ia.W_addr = '0; ia.W_data = '0; ia.R_en0 = 0; ia.R_addr0 = '0;
        ia.R_en1 = 0; ia.R_addr1 = '0; ia.Clr = 0;
        ib.W_en = 0; ib.W_addr = '0; ib.W_data = '0; ib.R_en0 = 0; ib.R_addr0 = '0;
        ib.R_en1 = 0; ib.R_addr1 = '0; ib.Clr = 0;
        if (b == 0) begin
            ia.W_en = we; ia.W_addr = 4'(wa); ia.W_data = wd; ia.Clr = clr;
            ia.R_en0 = r0; ia.R_addr0 = 4'(a0); ia.R_en1 = r1; ia.R_addr1 = 4'(a1);
            if (r0) qa0.push_back(e0);
            if (r1) qa1.push_back(e1);
        end else begin
            ib.W_en = we; ib.W_addr = 3'(wa); ib.W_data = wd[7:0]; ib.Clr = clr;
            ib.R_en0 = r0; ib.R_addr0 = 3'(a0); ib.R_en1 = r1; ib.R_addr1 = 3'(a1);
            if (r0) qb0.push_back(e0);
            if (r1) qb1.push_back(e1);
        end
        s.b = b; s.c = sc; s.bz = eb; s.dn = ed;
        sq.push_back(s);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int b, input bit sc, input bit eb, input bit ed);
        cyc(b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, eb, ed);
    endtask

    task automatic suite(input int b);
        int d;
        d = b != 0 ? 8 : 16;
        cyc(b, 1, 5, m(b, 16'hBEEF), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(b, 0, 0, 0, 1, 5, m(b, 16'hBEEF), 0, 0, 0, 0, 1, 0, 0);
        cyc(b, 1, 3, m(b, 16'h1234), 1, 3, m(b, 16'h1234), 1, 3, m(b, 16'h1234), 0, 1, 0, 0);
        cyc(b, 1, 6, m(b, 16'h0666), 1, 5, m(b, 16'hBEEF), 1, 6, m(b, 16'h0666), 0, 1, 0, 0);
        for (int i = 0; i < d; i++) cyc(b, 1, i, pat(b, i), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < d / 2; i++)
            cyc(b, 0, 0, 0, 1, i, pat(b, i), 1, i + d / 2, pat(b, i + d / 2), 0, 1, 0, 0);
        cyc(b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int j = 1; j <= d; j++)
            cyc(b, 1, (j + 3) % d, 16'hFFFF, 1, j - 1, 0, 1, d - 1, j == d ? 16'h0 : pat(b, d - 1),
                j == 5, 1, j < d, j == d);
        idle(b, 1, 0, 0);
        for (int i = 0; i < d / 2; i++) cyc(b, 0, 0, 0, 1, i, 0, 1, i + d / 2, 0, 0, 1, 0, 0);
    endtask

    initial begin
        idle(0, 1, 0, 0);
        idle(1, 1, 0, 0);
        cyc(0, 1, 2, 16'h7777, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        suite(0);
        cyc(0, 1, 7, 16'hAAAA, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int j = 1; j <= 16; j++)
            cyc(0, 0, 0, 0, 1, 7, j >= 8 ? 16'h0 : 16'hAAAA, 0, 0, 0, 0, 1, j < 16, j == 16);
        idle(0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 7, 0, 1, 7, 0, 0, 1, 0, 0);
        cyc(0, 1, 2, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 9, 16'h9999, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int j = 1; j <= 5; j++) idle(0, 1, 1, 0);
        rst_n = 1'b0;
        idle(0, 1, 0, 0);
        idle(0, 1, 0, 0);
        rst_n = 1'b1;
        cyc(0, 1, 1, 16'h0101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int j = 0; j < 20; j++) idle(0, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 0, 0, 1, i, i == 1 ? 16'h0101 : 16'h0, 1, i + 8, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        for (int j = 1; j <= 16; j++) idle(0, 1, j < 16, j == 16);
        idle(0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        suite(1);
        idle(0, 0, 0, 0);
        fin = 1'b1;
    end

    initial begin
        bit   va0, va1, vb0, vb1;
        st_t  s;
        forever begin
            @(posedge clk);
            va0 = ia.R_en0; va1 = ia.R_en1; vb0 = ib.R_en0; vb1 = ib.R_en1;
            @(negedge clk);
            if (sq.size() != 0) begin
                s = sq.pop_front();
                if (s.c) begin
                    chk(s.b != 0 ? "b_busy" : "a_busy", 16'(s.b != 0 ? ib.Busy : ia.Busy), 16'(s.bz));
                    chk(s.b != 0 ? "b_done" : "a_done", 16'(s.b != 0 ? ib.Done : ia.Done), 16'(s.dn));
                end
            end
            chk("a_rd0", ia.R_data0, va0 ? (qa0.size() != 0 ? qa0.pop_front() : 16'hxxxx) : 16'h0);
            chk("a_rd1", ia.R_data1, va1 ? (qa1.size() != 0 ? qa1.pop_front() : 16'hxxxx) : 16'h0);
            chk("b_rd0", 16'(ib.R_data0), vb0 ? (qb0.size() != 0 ? qb0.pop_front() : 16'hxxxx) : 16'h0);
            chk("b_rd1", 16'(ib.R_data1), vb1 ? (qb1.size() != 0 ? qb1.pop_front() : 16'hxxxx) : 16'h0);
            if (fin) begin
                chk("queues_drained", 16'(qa0.size() + qa1.size() + qb0.size() + qb1.size() + sq.size()), 16'h0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_n.md
REGFILE_N -- requirements
Module: regfile_n

Interface
REQ-001 The module SHALL have parameter N, default 16, meaning data width in bits (N >= 1).
REQ-002 The module SHALL have parameter A, default 4, meaning address width; depth D = 2^A registers.
REQ-003 The module SHALL have port Clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port W_data, input, N bits: write data.
REQ-006 The module SHALL have port W_addr, input, A bits: write address.
REQ-007 The module SHALL have port W_en, input, 1 bit: write enable.
REQ-008 The module SHALL have ports R_addr0 and R_addr1, inputs, A bits each: read addresses, ports 0 and 1.
REQ-009 The module SHALL have ports R_en0 and R_en1, inputs, 1 bit each: read enables.
REQ-010 The module SHALL have ports R_data0 and R_data1, outputs, N bits each: registered read data.
REQ-011 The module SHALL have port Clr, input, 1 bit: request to clear all registers.
REQ-012 The module SHALL have port Busy, output, 1 bit: high while the clear sequence runs.
REQ-013 The module SHALL have port Done, output, 1 bit: one-cycle pulse when the clear sequence completes.

Function
REQ-014 The module SHALL hold D registers of N bits, with no tristate outputs.
REQ-015 The module SHALL write W_data to register W_addr at the edge when W_en=1 and the FSM is in IDLE.
REQ-016 Each read port SHALL have 1-cycle latency: at the edge with R_enX=1, R_dataX <= reg[R_addrX].
REQ-017 At the edge with R_enX=0, R_dataX SHALL load 0.
REQ-018 Write-through bypass: when a write in the same cycle targets R_addrX, R_dataX SHALL load W_data, not the old value.
REQ-019 Both read ports SHALL be independent and may read the same address in the same cycle.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR, and an A-bit clear counter CC.
REQ-021 IDLE -> CLEAR: when Clr=1 at an edge in IDLE, the FSM SHALL enter CLEAR with CC=0.
REQ-022 If W_en=1 and Clr=1 in the same IDLE cycle, the write SHALL still occur; the clear later zeroes that register.
REQ-023 In CLEAR, each edge SHALL zero reg[CC] and increment CC.
REQ-024 CLEAR -> IDLE: the edge that zeroes reg[D-1] SHALL return the FSM to IDLE and set Done=1 for exactly the following cycle.
REQ-025 The clear SHALL take exactly D cycles with Busy=1, and Busy SHALL equal (state==CLEAR).
REQ-026 In CLEAR, W_en SHALL be ignored and the dropped write is not retried.
REQ-027 In CLEAR, Clr SHALL be ignored and SHALL NOT restart the sequence.
REQ-028 Reads during CLEAR SHALL return current contents; the address being zeroed this cycle SHALL read 0 (bypass rule applies).
REQ-029 CC wrap-around SHALL never be observable, because the FSM leaves CLEAR at CC=D-1.

Reset
REQ-030 When Reset=0, the module SHALL asynchronously zero all registers and R_data0/R_data1, clear Busy and Done, set CC=0, and set the FSM to IDLE.
REQ-031 Reset asserted mid-clear SHALL abort the sequence, leave all registers zero, and produce no Done pulse.
REQ-032 After Reset deasserts, the first active edge SHALL operate normally.

Verification
REQ-033 Reset, write 16'hBEEF to addr 5, then R_en0=1, R_addr0=5 -> R_data0=16'hBEEF one cycle later; R_data1=0 while R_en1=0.
REQ-034 Same cycle: W_en=1, W_addr=3, W_data=16'h1234, R_en0=R_en1=1, R_addr0=R_addr1=3 -> both outputs equal 16'h1234 at the next edge.
REQ-035 Fill all 16 registers, pulse Clr -> Busy high for exactly 16 cycles, Done for 1 cycle, then all reads return 0; W_en pulses during Busy have no effect.
REQ-036 Pulse Clr with W_en=1 to addr 7 (16'hAAAA) in the same cycle -> addr 7 reads 0 after Done.
REQ-037 Assert Reset=0 at clear cycle 6 -> Busy=0 immediately, no Done pulse, all registers 0; a new Clr afterwards takes 16 cycles.
REQ-038 Re-run REQ-033 to REQ-035 with N=8, A=3 -> clear takes 8 cycles and writes/reads use 8-bit data.
